// File: rtl/pin_pkg.sv
// Shared definitions for the PIN entry conditioner: FSM states and sizing constants.
package pin_pkg;

    localparam int PIN_DIGITS       = 4;
    localparam int DEBOUNCE_DEFAULT = 16;
    localparam int CNT_W            = 16;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        DEBOUNCE = 3'd1,
        HELD     = 3'd2,
        RELEASE  = 3'd3,
        CONFLICT = 3'd4
    } pin_entry_state_t;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer bringing one asynchronous push-button into the clk domain.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    output logic d_sync
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: the raw pin feeds the first stage, the first stage feeds the second.
    always_comb begin
        meta_d = d_raw;
        sync_d = meta_q;
    end

    // Synchronizer chain register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign d_sync = sync_q;

endmodule

// File: rtl/pin_entry_conditioner.sv
// Turns two bouncy push-buttons into clean, counted PIN digits for a downstream lock FSM.
// Each press yields exactly one digit strobe; a simultaneous press of both buttons is
// treated as a conflict and discarded. rst is expected to arrive release-synchronized.
module pin_entry_conditioner
    import pin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn0_raw,
    input  logic       btn1_raw,
    input  logic       clr,
    output logic       x,
    output logic       x_valid,
    output logic [1:0] digit_cnt,
    output logic       entry_done
);

    localparam logic [CNT_W-1:0] CNT_LAST       = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [1:0]       LAST_DIGIT_IDX = 2'(PIN_DIGITS - 1);

    logic s0, s1;
    logic cand_high, other_high;

    pin_entry_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cand_q, cand_d;
    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic [1:0]       digit_cnt_q, digit_cnt_d;
    logic             entry_done_q, entry_done_d;

    btn_sync u_sync0 (
        .clk    (clk),
        .rst    (rst),
        .d_raw  (btn0_raw),
        .d_sync (s0)
    );

    btn_sync u_sync1 (
        .clk    (clk),
        .rst    (rst),
        .d_raw  (btn1_raw),
        .d_sync (s1)
    );

    // cand holds the digit being debounced, which is also the index of its button.
    assign cand_high  = cand_q ? s1 : s0;
    assign other_high = cand_q ? s0 : s1;

    // Next-state and output logic; clr is applied last so it overrides any acceptance.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cand_d       = cand_q;
        x_d          = x_q;
        x_valid_d    = 1'b0;
        entry_done_d = 1'b0;
        digit_cnt_d  = digit_cnt_q;

        case (state_q)
            IDLE: begin
                if (s0 && s1) begin
                    state_d = CONFLICT;
                end else if (s0 || s1) begin
                    state_d = DEBOUNCE;
                    cnt_d   = '0;
                    cand_d  = s1;
                end
            end
            DEBOUNCE: begin
                if (!cand_high) begin
                    state_d = IDLE;
                end else if (other_high) begin
                    state_d = CONFLICT;
                end else if (cnt_q == CNT_LAST) begin
                    state_d      = HELD;
                    x_d          = cand_q;
                    x_valid_d    = 1'b1;
                    digit_cnt_d  = digit_cnt_q + 2'd1;
                    entry_done_d = (digit_cnt_q == LAST_DIGIT_IDX);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!s0 && !s1) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            RELEASE: begin
                if (s0 || s1) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CONFLICT: begin
                if (!s0 && !s1) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (clr) begin
            state_d      = (s0 || s1) ? HELD : IDLE;
            cnt_d        = '0;
            x_d          = x_q;
            x_valid_d    = 1'b0;
            entry_done_d = 1'b0;
            digit_cnt_d  = 2'd0;
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cand_q       <= 1'b0;
            x_q          <= 1'b0;
            x_valid_q    <= 1'b0;
            digit_cnt_q  <= 2'd0;
            entry_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cand_q       <= cand_d;
            x_q          <= x_d;
            x_valid_q    <= x_valid_d;
            digit_cnt_q  <= digit_cnt_d;
            entry_done_q <= entry_done_d;
        end
    end

    assign x          = x_q;
    assign x_valid    = x_valid_q;
    assign digit_cnt  = digit_cnt_q;
    assign entry_done = entry_done_q;

endmodule

// File: tb/tb_pin_entry_conditioner.sv
// Directed bench for pin_entry_conditioner with DEBOUNCE_CYCLES=4 (digit strobe after edge 7).
module tb_pin_entry_conditioner;
    import pin_pkg::*;

    logic       clk;
    logic       rst;
    logic       btn0_raw;
    logic       btn1_raw;
    logic       clr;
    logic       x;
    logic       x_valid;
    logic [1:0] digit_cnt;
    logic       entry_done;

    int errors;
    int checks;

    pin_entry_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn0_raw   (btn0_raw),
        .btn1_raw   (btn1_raw),
        .clr        (clr),
        .x          (x),
        .x_valid    (x_valid),
        .digit_cnt  (digit_cnt),
        .entry_done (entry_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        clr = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Clean press of one button held for 'hold' edges, then release and settle back to IDLE.
    task automatic press_digit(input logic digit, input int hold, output int pulses,
                               output logic x_at, output logic done_at, output logic [1:0] cnt_at);
        pulses = 0;
        x_at = 1'b0;
        done_at = 1'b0;
        cnt_at = 2'd0;
        if (digit) btn1_raw = 1'b1;
        else btn0_raw = 1'b1;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (x_valid) begin
                pulses++;
                x_at = x;
                done_at = entry_done;
                cnt_at = digit_cnt;
            end
        end
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (x_valid) pulses++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn0_raw = 1'b0;
        btn1_raw = 1'b1;
        clr = 1'b0;
        tick();
        tick();
        tick();
        checks++; if (x !== 1'b0) begin errors++; $display("[TB] FAIL reset_x: got %0b expected 0", x); end
        checks++; if (x_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_x_valid: got %0b expected 0", x_valid); end
        checks++; if (digit_cnt !== 2'd0) begin errors++; $display("[TB] FAIL reset_digit_cnt: got %0d expected 0", digit_cnt); end
        checks++; if (entry_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_entry_done: got %0b expected 0", entry_done); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state_q, IDLE); end
        btn1_raw = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (x_valid !== 1'b0 || digit_cnt !== 2'd0) begin errors++; $display("[TB] FAIL post_reset_quiet: got x_valid=%0b cnt=%0d expected 0/0", x_valid, digit_cnt); end
    endtask

    task automatic test_single_press();
        int pulses;
        pulses = 0;
        btn1_raw = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (x_valid) pulses++;
            checks++;
            if (x_valid !== (e == 7)) begin errors++; $display("[TB] FAIL single_strobe_edge%0d: got %0b expected %0b", e, x_valid, (e == 7)); end
            if (e == 6) begin
                checks++; if (digit_cnt !== 2'd0) begin errors++; $display("[TB] FAIL single_cnt_before: got %0d expected 0", digit_cnt); end
            end
            if (e == 7) begin
                checks++; if (x !== 1'b1) begin errors++; $display("[TB] FAIL single_x: got %0b expected 1", x); end
                checks++; if (digit_cnt !== 2'd1) begin errors++; $display("[TB] FAIL single_cnt_after: got %0d expected 1", digit_cnt); end
                checks++; if (entry_done !== 1'b0) begin errors++; $display("[TB] FAIL single_done: got %0b expected 0", entry_done); end
            end
        end
        btn1_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (x_valid) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL single_pulse_count: got %0d expected 1", pulses); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL single_back_idle: got %0d expected %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_bounce();
        int pulses;
        pulses = 0;
        for (int e = 1; e <= 20; e++) begin
            btn0_raw = (e <= 4) ? ((e % 2) == 1) : 1'b1;
            tick();
            if (x_valid) pulses++;
            checks++;
            if (x_valid !== (e == 11)) begin errors++; $display("[TB] FAIL bounce_strobe_edge%0d: got %0b expected %0b", e, x_valid, (e == 11)); end
            if (e == 11) begin
                checks++; if (x !== 1'b0) begin errors++; $display("[TB] FAIL bounce_x: got %0b expected 0", x); end
                checks++; if (digit_cnt !== 2'd2) begin errors++; $display("[TB] FAIL bounce_cnt: got %0d expected 2", digit_cnt); end
            end
        end
        btn0_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (x_valid) pulses++;
        end
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL bounce_pulse_count: got %0d expected 1", pulses); end
    endtask

    task automatic test_four_digits();
        logic       digits [4];
        int         pulses;
        logic       x_at;
        logic       done_at;
        logic [1:0] cnt_at;
        digits[0] = 1'b1;
        digits[1] = 1'b0;
        digits[2] = 1'b1;
        digits[3] = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press_digit(digits[i], 12, pulses, x_at, done_at, cnt_at);
            checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL four_pulses_d%0d: got %0d expected 1", i, pulses); end
            checks++; if (x_at !== digits[i]) begin errors++; $display("[TB] FAIL four_x_d%0d: got %0b expected %0b", i, x_at, digits[i]); end
            checks++; if (done_at !== (i == 3)) begin errors++; $display("[TB] FAIL four_done_d%0d: got %0b expected %0b", i, done_at, (i == 3)); end
            checks++; if (cnt_at !== 2'((i + 1) % 4)) begin errors++; $display("[TB] FAIL four_cnt_d%0d: got %0d expected %0d", i, cnt_at, (i + 1) % 4); end
        end
        checks++; if (digit_cnt !== 2'd0) begin errors++; $display("[TB] FAIL four_cnt_final: got %0d expected 0", digit_cnt); end
        checks++; if (entry_done !== 1'b0) begin errors++; $display("[TB] FAIL four_done_idle: got %0b expected 0", entry_done); end
    endtask

    task automatic test_conflict();
        int pulses;
        pulses = 0;
        btn0_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); if (x_valid) pulses++; end
        checks++; if (dut.state_q !== DEBOUNCE) begin errors++; $display("[TB] FAIL conflict_in_debounce: got %0d expected %0d", dut.state_q, DEBOUNCE); end
        btn1_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(); if (x_valid) pulses++; end
        checks++; if (dut.state_q !== CONFLICT) begin errors++; $display("[TB] FAIL conflict_enter: got %0d expected %0d", dut.state_q, CONFLICT); end
        for (int i = 0; i < 5; i++) begin tick(); if (x_valid) pulses++; end
        checks++; if (dut.state_q !== CONFLICT) begin errors++; $display("[TB] FAIL conflict_hold: got %0d expected %0d", dut.state_q, CONFLICT); end
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); if (x_valid) pulses++; end
        checks++; if (dut.state_q !== RELEASE) begin errors++; $display("[TB] FAIL conflict_release: got %0d expected %0d", dut.state_q, RELEASE); end
        for (int i = 0; i < 4; i++) begin tick(); if (x_valid) pulses++; end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL conflict_idle: got %0d expected %0d", dut.state_q, IDLE); end
        checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL conflict_no_digit: got %0d expected 0", pulses); end
        checks++; if (digit_cnt !== 2'd0) begin errors++; $display("[TB] FAIL conflict_cnt: got %0d expected 0", digit_cnt); end
    endtask

    task automatic test_clr();
        int         pulses;
        logic       x_at;
        logic       done_at;
        logic [1:0] cnt_at;
        do_reset();
        press_digit(1'b1, 12, pulses, x_at, done_at, cnt_at);
        press_digit(1'b0, 12, pulses, x_at, done_at, cnt_at);
        checks++; if (digit_cnt !== 2'd2 || x !== 1'b0) begin errors++; $display("[TB] FAIL clr_setup: got cnt=%0d x=%0b expected 2/0", digit_cnt, x); end
        pulses = 0;
        btn1_raw = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(); if (x_valid) pulses++; end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++; if (x_valid !== 1'b0) begin errors++; $display("[TB] FAIL clr_suppress_strobe: got %0b expected 0", x_valid); end
        checks++; if (entry_done !== 1'b0) begin errors++; $display("[TB] FAIL clr_suppress_done: got %0b expected 0", entry_done); end
        checks++; if (digit_cnt !== 2'd0) begin errors++; $display("[TB] FAIL clr_cnt: got %0d expected 0", digit_cnt); end
        checks++; if (x !== 1'b0) begin errors++; $display("[TB] FAIL clr_x_kept: got %0b expected 0", x); end
        checks++; if (dut.state_q !== HELD) begin errors++; $display("[TB] FAIL clr_state: got %0d expected %0d", dut.state_q, HELD); end
        for (int i = 0; i < 8; i++) begin tick(); if (x_valid) pulses++; end
        checks++; if (dut.state_q !== HELD) begin errors++; $display("[TB] FAIL clr_still_held: got %0d expected %0d", dut.state_q, HELD); end
        btn1_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); if (x_valid) pulses++; end
        checks++; if (pulses !== 0) begin errors++; $display("[TB] FAIL clr_no_digit: got %0d expected 0", pulses); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL clr_idle: got %0d expected %0d", dut.state_q, IDLE); end
    endtask

    task automatic test_reset_mid_hold();
        int pulses;
        pulses = 0;
        btn1_raw = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (dut.state_q !== HELD || digit_cnt !== 2'd1 || x !== 1'b1) begin errors++; $display("[TB] FAIL rsthold_setup: got state=%0d cnt=%0d x=%0b expected %0d/1/1", dut.state_q, digit_cnt, x, HELD); end
        rst = 1'b1;
        #1;
        checks++; if (x !== 1'b0 || x_valid !== 1'b0 || digit_cnt !== 2'd0 || entry_done !== 1'b0) begin errors++; $display("[TB] FAIL rsthold_async_clear: got x=%0b v=%0b cnt=%0d done=%0b expected all 0", x, x_valid, digit_cnt, entry_done); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("[TB] FAIL rsthold_state: got %0d expected %0d", dut.state_q, IDLE); end
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (x_valid) pulses++;
            checks++;
            if (x_valid !== (e == 7)) begin errors++; $display("[TB] FAIL rsthold_strobe_edge%0d: got %0b expected %0b", e, x_valid, (e == 7)); end
            if (e == 7) begin
                checks++; if (x !== 1'b1 || digit_cnt !== 2'd1) begin errors++; $display("[TB] FAIL rsthold_new_digit: got x=%0b cnt=%0d expected 1/1", x, digit_cnt); end
            end
        end
        btn1_raw = 1'b0;
        for (int i = 0; i < 12; i++) begin tick(); if (x_valid) pulses++; end
        checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL rsthold_pulse_count: got %0d expected 1", pulses); end
    endtask

    // Guard against a stuck simulation.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        clr = 1'b0;
        test_reset();
        test_single_press();
        test_bounce();
        test_four_digits();
        test_conflict();
        test_clr();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pin_entry_conditioner.md
PIN_ENTRY_CONDITIONER -- requirements
Module: pin_entry_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning the stable-sample count required to accept a press or a release (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports btn0_raw and btn1_raw, inputs, 1 bit each: asynchronous, bouncy push-buttons; btn0_raw enters digit 0, btn1_raw enters digit 1.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous entry abort, driven by the downstream lock FSM.
REQ-006 The block SHALL have port x, output, 1 bit: the last accepted digit, held between presses.
REQ-007 The block SHALL have port x_valid, output, 1 bit: one-cycle strobe marking a newly accepted digit on x.
REQ-008 The block SHALL have port digit_cnt, output, 2 bits: the number of digits accepted in the current 4-digit entry.
REQ-009 The block SHALL have port entry_done, output, 1 bit: one-cycle strobe asserted with the 4th digit's x_valid.

Function
REQ-010 Each raw button SHALL pass through a 2-flip-flop synchronizer; the FSM SHALL see only the synchronized values s0 and s1.
REQ-011 The FSM SHALL have states IDLE, DEBOUNCE, HELD, RELEASE and CONFLICT, plus a debounce counter cnt (16 bits) and a candidate-digit register cand.
REQ-012 In IDLE, exactly one of s0/s1 high SHALL cause a move to DEBOUNCE with cnt=0 and cand set to that button; both high SHALL cause a move to CONFLICT; neither high SHALL keep the FSM in IDLE.
REQ-013 In DEBOUNCE, with the candidate still high and the other button low, cnt SHALL increment; reaching cnt==DEBOUNCE_CYCLES-1 SHALL move the FSM to HELD and register x<=cand, x_valid<=1.
REQ-014 In DEBOUNCE, the candidate dropping SHALL cause a move to IDLE with no strobe; the other button rising SHALL cause a move to CONFLICT with no strobe.
REQ-015 In HELD, both buttons low SHALL cause a move to RELEASE with cnt=0.
REQ-016 In RELEASE, both low for DEBOUNCE_CYCLES consecutive samples SHALL cause a move to IDLE, and any button high SHALL cause a move back to HELD.
REQ-017 In CONFLICT, both buttons low SHALL cause a move to RELEASE with cnt=0, and no digit SHALL be produced.
REQ-018 Latency: with raw held stable high, x_valid SHALL be high in the cycle after rising edge DEBOUNCE_CYCLES+3, where edge 1 is the first edge sampling raw high.
REQ-019 x_valid and entry_done SHALL never exceed one cycle per physical press; holding a button SHALL produce exactly one digit.
REQ-020 digit_cnt SHALL increment on each x_valid and wrap 3->0 on the 4th digit, which SHALL also assert entry_done in the same cycle as x_valid.
REQ-021 clr SHALL force digit_cnt=0, suppress x_valid and entry_done that cycle, and move the FSM to HELD if s0|s1 is high, otherwise to IDLE; x SHALL be unchanged.
REQ-022 clr SHALL take priority over a simultaneous digit acceptance; that digit SHALL be discarded.

Reset
REQ-023 While rst is high, the block SHALL hold: synchronizers=0, state=IDLE, cnt=0, cand=0, x=0, x_valid=0, digit_cnt=0, entry_done=0.
REQ-024 rst asserted mid-debounce or mid-hold SHALL take effect immediately (asynchronously), and after release any still-pressed button SHALL be treated as a new press.
REQ-025 Deassertion of rst SHALL be synchronous to clk, with release synchronization handled at top level.

Structure
REQ-026 Shared package pin_pkg SHALL hold the state enum pin_entry_state_t, the constant PIN_DIGITS=4 and the constant DEBOUNCE_DEFAULT=16.
REQ-027 Sub-module btn_sync (2-FF synchronizer, async active-high reset) SHALL be instantiated twice.
REQ-028 All outputs SHALL be registered.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 The bench SHALL hold btn1_raw high for 20 cycles -> exactly one x_valid, x=1, seen after edge 7, and digit_cnt 0->1.
REQ-030 The bench SHALL apply btn0_raw bouncing 1,0,1,0 each cycle, then stable high -> no x_valid during the bounce, and exactly one x_valid with x=0 after the stable period.
REQ-031 The bench SHALL enter four clean presses 1,0,1,1 -> x_valid four times with x sequence 1,0,1,1, entry_done coincident with the 4th, and digit_cnt back to 0.
REQ-032 The bench SHALL raise btn0, then btn1 during DEBOUNCE, then release both -> no x_valid, and the FSM passes CONFLICT->RELEASE->IDLE.
REQ-033 The bench SHALL pulse clr in the cycle the 3rd digit would be accepted -> no x_valid, digit_cnt=0, and the FSM in HELD until release.
REQ-034 The bench SHALL pulse rst for 1 cycle mid-HELD with btn1 still pressed -> all outputs 0, then one new x_valid with x=1 after 7 edges.
